// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer that drives an external 1-bit full adder, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_cin,
    input  logic             fa_z,
    input  logic             fa_cout
);

    // state | meaning
    // IDLE  | waiting for start; adder inputs held at 0
    // RUN   | one operand bit per clock through the adder
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state == IDLE) && start;

    assign fa_x   = (state == RUN) && a_sh[0];
    assign fa_y   = (state == RUN) && b_sh[0];
    assign fa_cin = (state == RUN) && carry_q;

    // Only the upper WIDTH-1 bits of the result shifter need storage; the
    // newest bit comes straight from the adder on the final edge.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_next = fa_z;
        end else begin : g_wn
            logic [WIDTH-2:0] sum_sh;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_sh <= '0;
                end else if (accept) begin
                    sum_sh <= '0;
                end else if (state == RUN) begin
                    sum_sh <= sum_next[WIDTH-1:1];
                end
            end

            assign sum_next = {fa_z, sum_sh};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= fa_cout;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= sum_next;
                        cout  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        // carry into the MSB xor carry out of it
                        ovf   <= carry_q ^ fa_cout;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural full adder attached.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic         ovf;
    logic         fa_x, fa_y, fa_cin, fa_z, fa_cout;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_dones = 0;
    logic [W-1:0] hold_exp = '0;
    logic [W+1:0] sb[$];

    always #5 clk = ~clk;

    assign fa_z    = fa_x ^ fa_y ^ fa_cin;
    assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf     (ovf),
`endif
        .fa_x    (fa_x),
        .fa_y    (fa_y),
        .fa_cin  (fa_cin),
        .fa_z    (fa_z),
        .fa_cout (fa_cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {ovf, cout, sum} from integer addition and signed-range test
    function automatic logic [W+1:0] ref_result(input int ta, input int tb, input int tc);
        int total, sa, sbv, ssum;
        logic o;
        total = ta + tb + tc;
        sa    = (ta >= (1 << (W - 1))) ? ta - (1 << W) : ta;
        sbv   = (tb >= (1 << (W - 1))) ? tb - (1 << W) : tb;
        ssum  = sa + sbv + tc;
        o     = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
        return {o, 1'(total >> W), W'(total)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [W+1:0] e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf", 32'(ovf), 32'(e[W+1]));
`endif
            end
        end
    end

    // Called just after a clock edge while the DUT is idle.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        a = ta; b = tb; cin = tc; start = 1'b1;
        sb.push_back(ref_result(int'(ta), int'(tb), int'(tc)));
        exp_dones++;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_checked(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                               input bit noise);
        logic [W+1:0] e;
        bit seen;
        e = ref_result(int'(ta), int'(tb), int'(tc));
        issue(ta, tb, tc);
        for (int i = 0; i < W; i++) begin
            int mi, s;
            logic c;
            @(negedge clk);
            mi = (1 << i) - 1;
            s  = (int'(ta) & mi) + (int'(tb) & mi) + int'(tc);
            c  = 1'((s >> i) & 1);
            chk("fa_bits", 32'({busy, fa_x, fa_y, fa_cin}), 32'({1'b1, ta[i], tb[i], c}));
            if (i == 0) chk("sum_hold", 32'(sum), 32'(hold_exp));
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
            end
        end
        seen = 0;
        for (int i = 0; i < 3 * W + 4; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        start = 1'b0;
        chk("done_timeout", 32'(seen), 32'd1);
        chk("done_latency_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        hold_exp = e[W-1:0];
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        #2;
        chk("in_reset", 32'({busy, done, sum, cout, ovf}), 32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", 32'({busy, done, sum, cout, ovf, fa_x, fa_y, fa_cin}), 32'd0);
        end
        @(posedge clk); #1;

        run_checked(4'h3, 4'h5, 1'b0, 0);
        run_checked(4'hF, 4'h1, 1'b1, 0);
        run_checked(4'hA, 4'h3, 1'b0, 0);

        // start held high through RUN and DONE must not queue a second run
        issue(4'h3, 4'h5, 1'b0);
        d0 = done_cnt;
        a = 4'hF; b = 4'hF; start = 1'b1;
        repeat (W + 1) @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        chk("idle_after_ignored", 32'(busy), 32'd0);
        hold_exp = 4'h8;
        @(posedge clk); #1;

        // reset in the middle of a run
        issue(4'h3, 4'h5, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        exp_dones--;
        #1 chk("reset_abort", 32'({busy, done, sum, cout, ovf}), 32'd0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
        hold_exp = '0;
        @(posedge clk); #1;
        run_checked(4'h7, 4'h7, 1'b1, 0);

        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_checked(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'(n % 2));
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(exp_dones));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
